// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency unit
// results queue in a small FIFO and raise a bubble request once starved for too long.
module wb_port_arbiter #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned FIFO_DEPTH     = 2,
    parameter int unsigned MAX_WAIT       = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            RegWrite_W,
    input  logic [REG_ADDR_WIDTH-1:0]       rd_W,
    input  logic [DATA_WIDTH-1:0]           Result_W,
    input  logic                            lu_valid,
    output logic                            lu_ready,
    input  logic [REG_ADDR_WIDTH-1:0]       lu_rd,
    input  logic [DATA_WIDTH-1:0]           lu_data,
    output logic                            rf_we,
    output logic [REG_ADDR_WIDTH-1:0]       rf_rd,
    output logic [DATA_WIDTH-1:0]           rf_wd,
    output logic                            stall_req,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

    typedef enum logic {StNormal, StDrain} state_e;

    logic [REG_ADDR_WIDTH-1:0] mem_rd [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]     mem_wd [FIFO_DEPTH];

    logic [CntW-1:0]  count_q;
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [WaitW-1:0] wait_q;
    state_e           state_q;

    logic empty, full, pipe_req, push, pop, bypass, store;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CntW'(FIFO_DEPTH));
    assign pipe_req = RegWrite_W && (rd_W != '0);
    assign lu_ready = !rst && !full;
    assign push     = lu_valid && lu_ready;
    assign pop      = !pipe_req && !empty;
    // Bypass only when nothing older is queued, so acceptance order is preserved.
    assign bypass   = !pipe_req && empty && push && (lu_rd != '0);
    assign store    = push && (lu_rd != '0) && !bypass;

    assign fifo_count = count_q;
    assign stall_req  = (state_q == StDrain);

    always_comb begin
        rf_we = 1'b0;
        rf_rd = '0;
        rf_wd = '0;
        if (!rst) begin
            if (pipe_req) begin
                rf_we = 1'b1;
                rf_rd = rd_W;
                rf_wd = Result_W;
            end else if (!empty) begin
                rf_we = 1'b1;
                rf_rd = mem_rd[rd_ptr_q];
                rf_wd = mem_wd[rd_ptr_q];
            end else if (bypass) begin
                rf_we = 1'b1;
                rf_rd = lu_rd;
                rf_wd = lu_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_rd[wr_ptr_q] <= lu_rd;
            mem_wd[wr_ptr_q] <= lu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wait_q   <= '0;
            state_q  <= StNormal;
        end else begin
            if (store) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;

            case ({store, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (empty || pop) begin
                wait_q <= '0;
            end else if (pipe_req && (wait_q != WaitW'(MAX_WAIT))) begin
                wait_q <= wait_q + 1'b1;
            end

            case (state_q)
                StNormal: begin
                    if (!empty && pipe_req && (wait_q == WaitW'(MAX_WAIT - 1))) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if ((count_q == CntW'(1)) && pop && !store) begin
                        state_q <= StNormal;
                    end
                end
                default: state_q <= StNormal;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table plus multi-cycle sequences,
// with a scoreboard of expected LU writes checked against every register-file write.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite_W;
    logic [4:0]  rd_W;
    logic [31:0] Result_W;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        stall_req;
    logic [1:0]  fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wd;
    } wr_t;

    wr_t lu_q[$];

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[6];

    wb_port_arbiter #(
        .REG_ADDR_WIDTH(5),
        .DATA_WIDTH    (32),
        .FIFO_DEPTH    (2),
        .MAX_WAIT      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RegWrite_W(RegWrite_W),
        .rd_W      (rd_W),
        .Result_W  (Result_W),
        .lu_valid  (lu_valid),
        .lu_ready  (lu_ready),
        .lu_rd     (lu_rd),
        .lu_data   (lu_data),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wd     (rf_wd),
        .stall_req (stall_req),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, return at the falling edge.
    task automatic drive(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
        @(posedge clk);
        #1;
        RegWrite_W = rw;
        rd_W       = rd;
        Result_W   = res;
        lu_valid   = lv;
        lu_rd      = lrd;
        lu_data    = ldat;
        if (lv && lrd != 5'd0) lu_q.push_back({lrd, ldat});
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Every non-reset cycle: pipeline write if requested, else next queued LU result.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            logic pipe;
            logic exp_we;
            wr_t  e;
            pipe   = RegWrite_W && (rd_W != 5'd0);
            exp_we = pipe || (lu_q.size() > 0);
            check("mon_we", {63'd0, rf_we}, {63'd0, exp_we});
            if (rf_we && exp_we) begin
                if (pipe) begin
                    check("mon_pipe_rd", {59'd0, rf_rd}, {59'd0, rd_W});
                    check("mon_pipe_wd", {32'd0, rf_wd}, {32'd0, Result_W});
                end else begin
                    e = lu_q.pop_front();
                    check("mon_lu_rd", {59'd0, rf_rd}, {59'd0, e.rd});
                    check("mon_lu_wd", {32'd0, rf_wd}, {32'd0, e.wd});
                end
            end
        end
    end

    initial begin
        vecs[0] = '{1'b1, 5'd5, 32'hA5,   1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'hA5};
        vecs[1] = '{1'b1, 5'd0, 32'h55,   1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0};
        vecs[2] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'h11,   1'b1, 5'd7, 32'h11};
        vecs[3] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'hBAD,  1'b0, 5'd0, 32'h0};
        vecs[4] = '{1'b1, 5'd0, 32'hEE,   1'b1, 5'd9, 32'h99,   1'b1, 5'd9, 32'h99};
        vecs[5] = '{1'b0, 5'd3, 32'h77,   1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0};

        rst = 1'b1;
        RegWrite_W = 1'b0; rd_W = '0; Result_W = '0;
        lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
        @(negedge clk);
        check("rst_we", {63'd0, rf_we}, 64'd0);
        check("rst_ready", {63'd0, lu_ready}, 64'd0);
        check("rst_count", {62'd0, fifo_count}, 64'd0);
        check("rst_stall", {63'd0, stall_req}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single-cycle vectors from an empty FIFO: pipeline, bypass, discard, idle.
        foreach (vecs[i]) begin
            drive(vecs[i].rw, vecs[i].rd, vecs[i].res, vecs[i].lv, vecs[i].lrd, vecs[i].ldat);
            check($sformatf("vec%0d_we", i), {63'd0, rf_we}, {63'd0, vecs[i].exp_we});
            check($sformatf("vec%0d_rd", i), {59'd0, rf_rd}, {59'd0, vecs[i].exp_rd});
            check($sformatf("vec%0d_wd", i), {32'd0, rf_wd}, {32'd0, vecs[i].exp_wd});
            check($sformatf("vec%0d_ready", i), {63'd0, lu_ready}, 64'd1);
            check($sformatf("vec%0d_count", i), {62'd0, fifo_count}, 64'd0);
        end

        // Two LU results queue behind a busy pipeline, then drain in order.
        drive(1'b1, 5'd10, 32'h1000, 1'b1, 5'd3, 32'h33);
        drive(1'b1, 5'd11, 32'h1001, 1'b1, 5'd4, 32'h44);
        check("q_count1", {62'd0, fifo_count}, 64'd1);
        drive(1'b1, 5'd12, 32'h1002, 1'b0, 5'd0, 32'h0);
        check("q_count2", {62'd0, fifo_count}, 64'd2);
        check("q_full_ready", {63'd0, lu_ready}, 64'd0);
        idle();
        check("q_pop1_rd", {59'd0, rf_rd}, 64'd3);
        check("q_pop1_wd", {32'd0, rf_wd}, 64'h33);
        check("q_pop1_ready", {63'd0, lu_ready}, 64'd0);
        idle();
        check("q_pop2_rd", {59'd0, rf_rd}, 64'd4);
        check("q_pop2_wd", {32'd0, rf_wd}, 64'h44);
        check("q_pop2_ready", {63'd0, lu_ready}, 64'd1);
        check("q_pop2_count", {62'd0, fifo_count}, 64'd1);
        idle();
        check("q_empty_count", {62'd0, fifo_count}, 64'd0);
        check("q_empty_we", {63'd0, rf_we}, 64'd0);

        // Starvation: one entry loses four cycles, stall from the fifth.
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd6, 32'h66);
        for (int c = 1; c <= 4; c++) begin
            drive(1'b1, 5'd1, 32'h1 + c, 1'b0, 5'd0, 32'h0);
            check($sformatf("starve_c%0d_stall", c), {63'd0, stall_req}, 64'd0);
        end
        idle();
        check("starve_stall", {63'd0, stall_req}, 64'd1);
        check("starve_pop_rd", {59'd0, rf_rd}, 64'd6);
        idle();
        check("starve_release", {63'd0, stall_req}, 64'd0);
        check("starve_count", {62'd0, fifo_count}, 64'd0);

        // lu_rd == 0 accepted while the pipe is busy but never stored or written.
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd0, 32'hDEAD);
        check("zero_ready", {63'd0, lu_ready}, 64'd1);
        idle();
        check("zero_count", {62'd0, fifo_count}, 64'd0);
        check("zero_we", {63'd0, rf_we}, 64'd0);

        // Full FIFO in drain state, then reset mid-operation discards both entries.
        drive(1'b1, 5'd8, 32'h80, 1'b1, 5'd13, 32'hD0);
        drive(1'b1, 5'd8, 32'h81, 1'b1, 5'd14, 32'hE0);
        for (int c = 0; c < 3; c++) drive(1'b1, 5'd8, 32'h82 + c, 1'b0, 5'd0, 32'h0);
        drive(1'b1, 5'd8, 32'h90, 1'b0, 5'd0, 32'h0);
        check("pre_rst_stall", {63'd0, stall_req}, 64'd1);
        check("pre_rst_count", {62'd0, fifo_count}, 64'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        lu_q.delete();
        @(negedge clk);
        check("mid_rst_we", {63'd0, rf_we}, 64'd0);
        check("mid_rst_rd", {59'd0, rf_rd}, 64'd0);
        check("mid_rst_count", {62'd0, fifo_count}, 64'd0);
        check("mid_rst_stall", {63'd0, stall_req}, 64'd0);
        check("mid_rst_ready", {63'd0, lu_ready}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle();
        check("post_rst_we", {63'd0, rf_we}, 64'd0);
        check("post_rst_ready", {63'd0, lu_ready}, 64'd1);
        check("post_rst_stall", {63'd0, stall_req}, 64'd0);
        idle();
        idle();
        check("post_rst_count", {62'd0, fifo_count}, 64'd0);
        check("sb_drained", 64'(lu_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
